// File: rtl/toggle_sequence_checker_pkg.sv
// toggle_pkg: shared state encoding, token codes and successor function for the toggle checker
package toggle_pkg;

    typedef enum logic [1:0] {IDLE, EXP_A, EXP_B, FAULT} state_e;

    localparam logic [1:0] TOK_A = 2'b01;
    localparam logic [1:0] TOK_B = 2'b10;

    // Legal successor of a token; 00 marks an illegal code (00/11)
    function automatic logic [1:0] next_tok(input logic [1:0] t);
        return (t == TOK_A) ? TOK_B : (t == TOK_B) ? TOK_A : 2'b00;
    endfunction

endpackage

// File: rtl/toggle_sat_counter.sv
// toggle_sat_counter: up-counter that sticks at all-ones instead of wrapping
module toggle_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count on inc, hold once saturated
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/toggle_sequence_checker.sv
// toggle_sequence_checker: checks strict 01/10 alternation; optional idle watchdog via TOGGLE_CHK_TIMEOUT_EN
module toggle_sequence_checker
    import toggle_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MAX_ERR = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    input  logic [1:0]       tok,
    input  logic             resync,
    output logic [1:0]       expected,
    output logic             ack,
    output logic             err_pulse,
    output logic             fault,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] MAX_E = CNT_W'(MAX_ERR);

    if (MAX_ERR < 1 || MAX_ERR > (1 << CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_param
        $error("toggle_sequence_checker: MAX_ERR or TIMEOUT out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             good_inc, err_inc;

`ifdef TOGGLE_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign expected  = (state_q == EXP_A) ? TOK_A : (state_q == EXP_B) ? TOK_B : 2'b00;
    assign fault     = (state_q == FAULT);
    assign ack       = ack_q;
    assign err_pulse = err_q;

    // Next state: resync wins, FAULT ignores tokens, otherwise accept the successor or count an error
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        good_inc = 1'b0;
        err_inc  = 1'b0;
`ifdef TOGGLE_CHK_TIMEOUT_EN
        wd_d     = '0;
`endif
        if (resync) begin
            state_d  = IDLE;
            consec_d = '0;
        end else if (state_q != FAULT && tok_valid) begin
            if (next_tok(tok) != 2'b00 && (state_q == IDLE || tok == expected)) begin
                ack_d    = 1'b1;
                good_inc = (state_q != IDLE);
                consec_d = '0;
                state_d  = (next_tok(tok) == TOK_A) ? EXP_A : EXP_B;
            end else begin
                err_d    = 1'b1;
                err_inc  = 1'b1;
                consec_d = consec_q + 1'b1;
                if (consec_d == MAX_E) state_d = FAULT;
            end
        end
`ifdef TOGGLE_CHK_TIMEOUT_EN
        else if (state_q == EXP_A || state_q == EXP_B) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_W'(TIMEOUT)) begin
                wd_d     = '0;
                err_d    = 1'b1;
                err_inc  = 1'b1;
                consec_d = consec_q + 1'b1;
                state_d  = (consec_d == MAX_E) ? FAULT : IDLE;
            end
        end
`endif
    end

    // State, consecutive-error count and registered pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            consec_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

`ifdef TOGGLE_CHK_TIMEOUT_EN
    // Idle-cycle watchdog while waiting for the next token
    always_ff @(posedge clk) begin
        if (!rst_n) wd_q <= '0;
        else wd_q <= wd_d;
    end
`endif

    toggle_sat_counter #(.W(CNT_W)) u_good (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (good_inc),
        .cnt  (good_cnt)
    );

    toggle_sat_counter #(.W(CNT_W)) u_err (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .cnt  (err_cnt)
    );

endmodule

// File: doc/toggle_sequence_checker.md
Name: toggle_sequence_checker

Overview:
- Receiving end of the one-hot alternating toggle protocol; the generator side emits 2'b01 and 2'b10 in strict alternation.
- Samples qualified tokens and checks that each one is the legal successor of the previous token.
- Flags repeats and illegal codes (00/11); keeps saturating good/error counters.
- Enters a FAULT state after too many consecutive errors; sits between a toggle source and the status/debug logic.

Parameters:
- CNT_W, 8, width of good_cnt and err_cnt (saturating).
- MAX_ERR, 3, consecutive errors that force FAULT (1..2^CNT_W-1).
- TIMEOUT, 16, idle cycles before a timeout error; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- tok_valid  input  1  tok is sampled this cycle.
- tok  input  2  toggle token.
- resync  input  1  synchronous return to IDLE; counters kept.
- expected  output  2  next legal token: 01/10, or 00 in IDLE/FAULT.
- ack  output  1  1-cycle pulse, token accepted.
- err_pulse  output  1  1-cycle pulse, token rejected or timeout.
- fault  output  1  high while in FAULT.
- good_cnt  output  CNT_W  count of accepted legal transitions.
- err_cnt  output  CNT_W  count of errors.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; expected=00; ack=0; err_pulse=0; fault=0.
  - good_cnt=0; err_cnt=0; consecutive-error counter=0.
- Outputs are registered: every effect appears in the cycle after the sampling edge (latency 1).
- States:
  - IDLE: waits for the first legal token, which sets phase.
    - tok=01 -> EXP_B.
    - tok=10 -> EXP_A.
    - ack=1; good_cnt is not incremented (no transition yet).
  - EXP_A: expected=01.
    - tok=01 -> good_cnt+1, ack, -> EXP_B.
  - EXP_B: expected=10.
    - tok=10 -> good_cnt+1, ack, -> EXP_A.
  - FAULT: fault=1, expected=00. tok_valid is ignored (no ack, no err, no count). Exit only via resync or reset.
- Errors (any non-IDLE, non-FAULT state, tok_valid=1):
  - Repeat of the previous token: err_pulse, err_cnt+1, state unchanged.
  - tok=00/11 in any non-FAULT state: err_pulse, err_cnt+1, state unchanged.
  - Consecutive-error counter increments on each error and clears on any ack.
  - When it reaches MAX_ERR -> FAULT in the same update.
- tok_valid=0: no state or count change.
- Counters saturate at all-ones and never wrap.
- resync=1: -> IDLE, consecutive-error counter=0, ack/err_pulse=0. good_cnt/err_cnt are held.
  - resync beats tok_valid in the same cycle; the token is dropped.
- Reset mid-stream: all state cleared regardless of other inputs; rst_n has priority over resync.

Optional Feature:
- Macro: TOGGLE_CHK_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles in EXP_A/EXP_B with tok_valid=0; it clears on any tok_valid, on state change, and in IDLE/FAULT.
  - When the count reaches TIMEOUT: err_pulse, err_cnt+1, consecutive-error counter+1, state -> IDLE (unless MAX_ERR is reached, then FAULT).
- Undefined: no watchdog logic; a stalled source is never flagged.

Decomposition:
- Package toggle_pkg:
  - State enum {IDLE, EXP_A, EXP_B, FAULT}.
  - Constants TOK_A=2'b01, TOK_B=2'b10.
  - Function next_tok(tok) returning the successor (00 for illegal input).
- Sub-module toggle_sat_counter (parameter W; inputs clk, rst_n, inc; output cnt). Instanced twice: good_cnt, err_cnt.

Test Plan:
- Reset, then tokens 01,10,01,10 on consecutive cycles -> ack each cycle, good_cnt=3, err_cnt=0, expected ends 01.
- Tokens 01,01,10 -> second 01 gives err_pulse, err_cnt=1; then 10 acked, good_cnt=1, consecutive-error counter cleared.
- From EXP_A, tok=11 three times with MAX_ERR=3 -> err_cnt=3, fault=1 after the third; a further tok=01 gives no ack and no count change; resync -> IDLE, fault=0, err_cnt still 3.
- CNT_W=2, nine legal alternations -> good_cnt sticks at 3.
- resync and tok_valid (tok=10) in the same cycle from EXP_B -> IDLE, no ack, good_cnt unchanged; rst_n=0 mid-stream -> all outputs zero next cycle.
- With TOGGLE_CHK_TIMEOUT_EN and TIMEOUT=16: after token 01, hold tok_valid=0 for 16 cycles -> err_pulse, err_cnt=1, state IDLE. Without the macro: no error.
